// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the register-file FIFO controller.
// State encodings and default geometry.
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_CNT_W  = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] WRITE    = 3'b001;
  localparam logic [2:0] WR_ERROR = 3'b010;
  localparam logic [2:0] READ     = 3'b011;
  localparam logic [2:0] RD_ERROR = 3'b100;

endpackage

// File: rtl/fifo_ctrl_ns.sv
// Next-state selection for the FIFO controller.
// Simultaneous read and write requests fall through to IDLE.
module fifo_ctrl_ns
  import fifo_ctrl_pkg::*;
(
  input  logic   wr_en,
  input  logic   rd_en,
  input  logic   full,
  input  logic   empty,
  output state_t next
);

  always_comb begin
    next = IDLE;
    unique case (1'b1)
      wr_en & ~rd_en & ~full:  next = WRITE;
      wr_en & ~rd_en & full:   next = WR_ERROR;
      rd_en & ~wr_en & ~empty: next = READ;
      rd_en & ~wr_en & empty:  next = RD_ERROR;
      default:                 next = IDLE;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and strobe sequencing for the
// 8-entry register-file FIFO.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int CNT_W  = FIFO_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic              re,
  output logic [ADDR_W-1:0] rAddr,
  output logic [CNT_W-1:0]  data_count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  state_t            state;
  state_t            next;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W-1:0] head;

  assign full  = (data_count == CNT_W'(DEPTH));
  assign empty = (data_count == '0);

  fifo_ctrl_ns u_ns (
    .wr_en (wr_en),
    .rd_en (rd_en),
    .full  (full),
    .empty (empty),
    .next  (next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tail       <= '0;
      head       <= '0;
      data_count <= '0;
      wAddr      <= '0;
      rAddr      <= '0;
    end else begin
      state <= next;
      if (next == WRITE) begin
        wAddr      <= tail;
        tail       <= tail + ADDR_W'(1);
        data_count <= data_count + CNT_W'(1);
      end else if (next == READ) begin
        rAddr      <= head;
        head       <= head + ADDR_W'(1);
        data_count <= data_count - CNT_W'(1);
      end
    end
  end

  // Gate we with reset so a reset edge never lands a write in the file.
  assign we     = (state == WRITE) & ~reset;
  assign re     = (state == READ);
  assign wr_ack = (state == WRITE);
  assign wr_err = (state == WR_ERROR);
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios then
// random traffic against a queue-based FIFO occupancy model.
module tb_fifo_ctrl;

  logic       clk = 0;
  logic       reset, wr_en, rd_en;
  logic       we, re, full, empty;
  logic [2:0] wAddr, rAddr;
  logic [3:0] data_count;
  logic       wr_ack, wr_err, rd_ack, rd_err;

  int n_cmp = 0;
  int n_bad = 0;

  int q[$];
  int wp;
  int m_waddr, m_raddr;
  bit m_wack, m_werr, m_rack, m_rerr;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .wAddr      (wAddr),
    .re         (re),
    .rAddr      (rAddr),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit w, input bit r, input bit rs);
    m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
    if (rs) begin
      q.delete();
      wp = 0; m_waddr = 0; m_raddr = 0;
    end else if (w && !r) begin
      if (q.size() < 8) begin
        q.push_back(wp);
        m_waddr = wp;
        wp = (wp + 1) % 8;
        m_wack = 1;
      end else m_werr = 1;
    end else if (r && !w) begin
      if (q.size() > 0) begin
        m_raddr = q.pop_front();
        m_rack = 1;
      end else m_rerr = 1;
    end
  endtask

  task automatic check_all(input bit rs);
    chk("we", int'(we), int'(m_wack & ~rs));
    chk("re", int'(re), int'(m_rack));
    chk("wAddr", int'(wAddr), m_waddr);
    chk("rAddr", int'(rAddr), m_raddr);
    chk("count", int'(data_count), q.size());
    chk("full", int'(full), int'(q.size() == 8));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("wr_ack", int'(wr_ack), int'(m_wack));
    chk("wr_err", int'(wr_err), int'(m_werr));
    chk("rd_ack", int'(rd_ack), int'(m_rack));
    chk("rd_err", int'(rd_err), int'(m_rerr));
  endtask

  task automatic step(input bit w, input bit r, input bit rs);
    @(negedge clk);
    wr_en = w; rd_en = r; reset = rs;
    #1;
    chk("we_comb", int'(we), int'(m_wack & ~rs));
    @(posedge clk);
    model_edge(w, r, rs);
    #1;
    check_all(rs);
  endtask

  task automatic do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
  endtask

  initial begin
    reset = 1; wr_en = 0; rd_en = 0;
    wp = 0; m_waddr = 0; m_raddr = 0;
    m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;

    do_reset();
    step(0, 0, 0);

    // nine writes from empty: last one is rejected
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    chk("t2_count", int'(data_count), 8);
    chk("t2_err", int'(wr_err), 1);

    do_reset();
    step(0, 1, 0);
    chk("t3_rderr", int'(rd_err), 1);

    // wrap-around of both pointers
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("t4_full", int'(full), 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("t4_last_raddr", int'(rAddr), 2);
    chk("t4_empty", int'(empty), 1);

    // simultaneous requests at count 4
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    chk("t5_count", int'(data_count), 4);

    // reset asserted during a write cycle at count 5
    step(1, 0, 0);
    chk("t6_count5", int'(data_count), 5);
    step(0, 0, 1);
    chk("t6_count0", int'(data_count), 0);
    step(0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int p = $urandom_range(0, 99);
      bit rs = ($urandom_range(0, 99) < 3);
      bit w, r;
      if (p < 45) begin w = 1; r = 0; end
      else if (p < 85) begin w = 0; r = 1; end
      else if (p < 93) begin w = 1; r = 1; end
      else begin w = 0; r = 0; end
      if (i % 200 < 60 && !w && r) begin w = 1; r = 0; end
      step(w, r, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
